// File: rtl/adder_resp_checker_pkg.sv
// Shared definitions for the adder response checker: FSM state encodings and default widths.
package adder_resp_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_REPORT = 2'd2
    } chk_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/adder_cov_bitmap.sv
// One bit per {A,B,Cin} combination; all_set is a registered AND-reduce of the next bitmap value.
module adder_cov_bitmap
    import adder_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              set_en,
    input  logic [2*WIDTH:0]  set_idx,
    output logic              all_set
);

    localparam int NVEC = 2 ** (2 * WIDTH + 1);

    logic [NVEC-1:0] bits_q;
    logic [NVEC-1:0] bits_d;

    always_comb begin
        bits_d = bits_q;
        if (clr) begin
            bits_d = '0;
        end else if (set_en) begin
            bits_d[set_idx] = 1'b1;
        end
    end

    // Reducing the next value keeps all_set aligned with the vector counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q  <= '0;
            all_set <= 1'b0;
        end else begin
            bits_q  <= bits_d;
            all_set <= &bits_d;
        end
    end

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for a WIDTH-bit full adder: golden compare, saturating counters,
// first-failure capture, coverage tracking and a done/pass verdict.
//
// state  | meaning
// IDLE   | after reset, vectors ignored
// CHECK  | vectors are checked, counted and recorded in the coverage bitmap
// REPORT | results frozen, done asserted, pass valid
module adder_resp_checker
    import adder_resp_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               vld_in,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Cin,
    input  logic [WIDTH-1:0]   Sum,
    input  logic               Cout,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               first_fail_vld,
    output logic [2*WIDTH:0]   first_fail_vec,
    output logic               cov_full
);

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic             clr;
    logic             accept;
    logic             mismatch;
    logic [WIDTH:0]   expected;
    logic [2*WIDTH:0] vec_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CHECK;
                    clr     = 1'b1;
                end
            end
            ST_CHECK: begin
                if (start) begin
                    clr = 1'b1;
                end else if (stop) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (start) begin
                    state_d = ST_CHECK;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A restart takes priority over a vector presented in the same cycle.
    assign accept   = (state_q == ST_CHECK) && vld_in && !start;
    assign expected = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign mismatch = ({Cout, Sum} != expected);
    assign vec_idx  = {A, B, Cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (clr) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (accept) begin
            if (!(&vec_cnt)) begin
                vec_cnt <= vec_cnt + 1'b1;
            end
            if (mismatch && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (mismatch && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_vec <= vec_idx;
            end
        end
    end

    adder_cov_bitmap #(
        .WIDTH (WIDTH)
    ) u_cov_bitmap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .set_en  (accept),
        .set_idx (vec_idx),
        .all_set (cov_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state_q == ST_REPORT);
            pass <= (state_q == ST_REPORT) && (err_cnt == '0) && cov_full;
        end
    end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Scoreboard bench for adder_resp_checker: the stimulus side pushes model results, a monitor compares.
module tb_adder_resp_checker;

    localparam int W    = 4;
    localparam int CW   = 16;
    localparam int NVEC = 512;

    typedef struct packed {
        logic [CW-1:0] vec;
        logic [CW-1:0] err;
        logic          ffv;
        logic [8:0]    ffvec;
        logic          cov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          vld_in = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Cin = 1'b0;
    logic [W-1:0]  Sum = '0;
    logic          Cout = 1'b0;
    logic          done;
    logic          pass;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] err_cnt;
    logic          first_fail_vld;
    logic [8:0]    first_fail_vec;
    logic          cov_full;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0=idle, 1=checking, 2=reporting
    int         m_st = 0;
    int         m_vec = 0;
    int         m_err = 0;
    bit         m_ffv = 0;
    int         m_ffvec = 0;
    bit         m_seen [NVEC];
    exp_t       sb [$];
    int         perm [NVEC];

    always #5 clk = ~clk;

    adder_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vld_in(vld_in),
        .A(A), .B(B), .Cin(Cin), .Sum(Sum), .Cout(Cout),
        .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec), .cov_full(cov_full)
    );

    function automatic bit m_cov();
        for (int i = 0; i < NVEC; i++) if (!m_seen[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_clear();
        m_vec = 0; m_err = 0; m_ffv = 0; m_ffvec = 0;
        for (int i = 0; i < NVEC; i++) m_seen[i] = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the model is advanced at the sampling edge.
    task automatic drive(input int a, input int b, input int c, input int resp,
                         input bit st, input bit sp, input bit v);
        int idx;
        exp_t e;
        @(negedge clk);
        A = a[3:0]; B = b[3:0]; Cin = c[0]; {Cout, Sum} = resp[4:0];
        start = st; stop = sp; vld_in = v;
        @(posedge clk);
        if (v && m_st == 1 && !st) begin
            idx = a * 32 + b * 2 + c;
            if (m_vec < 65535) m_vec++;
            if (resp != a + b + c) begin
                if (m_err < 65535) m_err++;
                if (!m_ffv) begin m_ffv = 1; m_ffvec = idx; end
            end
            m_seen[idx] = 1'b1;
        end
        if (st) begin
            m_st = 1;
            m_clear();
        end else if (sp && m_st == 1) begin
            m_st = 2;
        end
        if (v) begin
            e.vec = m_vec[CW-1:0]; e.err = m_err[CW-1:0]; e.ffv = m_ffv;
            e.ffvec = m_ffvec[8:0]; e.cov = m_cov();
            sb.push_back(e);
        end
        #1;
        start = 0; stop = 0; vld_in = 0;
    endtask

    task automatic vec_ok(input int a, input int b, input int c);
        drive(a, b, c, a + b + c, 0, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic shuffle();
        int j, t;
        for (int i = 0; i < NVEC; i++) perm[i] = i;
        for (int i = NVEC - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    task automatic check_report(input string tag);
        idle(3);
        chk({tag, " done"}, done, m_st == 2);
        chk({tag, " pass"}, pass, (m_st == 2) && m_err == 0 && m_cov());
        chk({tag, " vec_cnt"}, vec_cnt, m_vec);
        chk({tag, " err_cnt"}, err_cnt, m_err);
        chk({tag, " cov_full"}, cov_full, m_cov());
        chk({tag, " ff_vld"}, first_fail_vld, m_ffv);
        chk({tag, " ff_vec"}, first_fail_vec, m_ffvec);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {vec_cnt, err_cnt, first_fail_vld, first_fail_vec, cov_full};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL scoreboard: got vec=%0d err=%0d ffv=%0d ffvec=%h cov=%0d expected vec=%0d err=%0d ffv=%0d ffvec=%h cov=%0d",
                         vec_cnt, err_cnt, first_fail_vld, first_fail_vec, cov_full,
                         e.vec, e.err, e.ffv, e.ffvec, e.cov);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, r;
        m_clear();
        #23;
        chk("reset done", done, 0);
        chk("reset vec_cnt", vec_cnt, 0);
        chk("reset cov_full", cov_full, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: exhaustive, all correct, in random order
        drive(0, 0, 0, 0, 1, 0, 0);
        shuffle();
        for (int i = 0; i < NVEC; i++) vec_ok(perm[i] / 32, (perm[i] / 2) % 16, perm[i] % 2);
        drive(0, 0, 0, 0, 0, 1, 0);
        check_report("t1");
        chk("t1 vec_cnt abs", vec_cnt, 512);
        chk("t1 pass abs", pass, 1);

        // 2: exhaustive with one bad response
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < NVEC; i++) begin
            a = i / 32; b = (i / 2) % 16; c = i % 2;
            if (a == 3 && b == 5 && c == 1) drive(a, b, c, 0, 0, 0, 1);
            else vec_ok(a, b, c);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        check_report("t2");
        chk("t2 ff_vec abs", first_fail_vec, 9'h06B);
        chk("t2 err abs", err_cnt, 1);

        // 3: Cin=0 half only
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 256; i++) vec_ok(i / 16, i % 16, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check_report("t3");

        // 4: vld in IDLE ignored, then start&&stop enters CHECK
        rst_n = 1'b0; #3; rst_n = 1'b1;
        m_st = 0; m_clear();
        repeat (10) vec_ok($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(1, 0));
        chk("t4 idle vec_cnt", vec_cnt, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        idle(2);
        chk("t4 done", done, 0);
        vec_ok(7, 9, 1);
        idle(1);

        // 5: async reset mid-stream
        drive(0, 0, 0, 0, 1, 0, 0);
        repeat (100) vec_ok($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(1, 0));
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst outputs", {done, pass, vec_cnt, err_cnt, first_fail_vld, first_fail_vec, cov_full}, 0);
        #2 rst_n = 1'b1;
        m_st = 0; m_clear();
        vec_ok(1, 2, 0);
        idle(1);
        chk("t5 idle after reset", vec_cnt, 0);

        // 6: one vector repeated 600 times, then restart
        drive(0, 0, 0, 0, 1, 0, 0);
        repeat (600) drive(15, 15, 1, 31, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        check_report("t6");
        chk("t6 vec abs", vec_cnt, 600);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        chk("t6 restart vec", vec_cnt, 0);
        chk("t6 restart cov", cov_full, 0);

        // 7: random vectors with random corruption; last one arrives with stop
        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(15, 0); b = $urandom_range(15, 0); c = $urandom_range(1, 0);
            r = a + b + c;
            if ($urandom_range(7, 0) == 0) r = (r + $urandom_range(31, 1)) % 32;
            drive(a, b, c, r, 0, (i == 399), 1);
        end
        check_report("t7");

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
